// File: rtl/netflix_trace_decoder_pkg.sv
// rtl/netflix_trace_decoder_pkg.sv - shared status-word layout, state encoding and record layout
package netflix_trace_decoder_pkg;

  localparam int WORD_W     = 15;
  localparam int PERSON_W   = 3;
  localparam int WEEK_W     = 7;
  localparam int FIN_W      = 2;
  localparam int ST_W       = 3;
  localparam int ST_LSB     = 0;
  localparam int FIN_LSB    = 3;
  localparam int WEEK_LSB   = 5;
  localparam int PERSON_LSB = 12;

  localparam logic [ST_W-1:0] NS         = 3'd0;
  localparam logic [ST_W-1:0] S1         = 3'd1;
  localparam logic [ST_W-1:0] S2         = 3'd2;
  localparam logic [ST_W-1:0] S3         = 3'd3;
  localparam logic [ST_W-1:0] S4         = 3'd4;
  localparam logic [ST_W-1:0] S5         = 3'd5;
  localparam logic [ST_W-1:0] F          = 3'd6;
  localparam logic [ST_W-1:0] ST_ILLEGAL = 3'd7;

  localparam logic [FIN_W-1:0] FIN_LOCK = 2'd3;

  localparam int REC_W        = 16;
  localparam int REC_LOCKED   = 0;
  localparam int REC_MAX_ST   = 1;
  localparam int REC_FIN_CNT  = 4;
  localparam int REC_FIN_WEEK = 6;
  localparam int REC_PERSON   = 13;

  typedef enum logic {TRK_IDLE, TRK_TRACK} trk_state_t;

  function automatic logic [REC_W-1:0] pack_record(
    input logic [PERSON_W-1:0] person,
    input logic [WEEK_W-1:0]   finish_week,
    input logic [FIN_W-1:0]    finish_count,
    input logic [ST_W-1:0]     max_state,
    input logic                locked
  );
    return {person, finish_week, finish_count, max_state, locked};
  endfunction

endpackage

// File: rtl/netflix_rpt_fifo.sv
// rtl/netflix_rpt_fifo.sv - synchronous FIFO whose empty flag lags a push into an empty queue by one cycle
module netflix_rpt_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_CNT  = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == FULL_CNT);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // Deassert one cycle after the first push, but assert at once when the last entry leaves.
      empty <= (count == '0) || (do_pop && !do_push && count == ONE_CNT);
    end
  end

endmodule

// File: rtl/netflix_trace_decoder.sv
// rtl/netflix_trace_decoder.sv - viewer-status tracker building per-person records into a report FIFO
// Optional counters rec_count/drop_count are built when NETFLIX_DEC_STATS_EN is defined.
module netflix_trace_decoder
  import netflix_trace_decoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] status_word,
  input  logic              status_valid,
  input  logic              flush,
  output logic [REC_W-1:0]  rpt_data,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic              overflow,
  output logic              illegal_state,
  output logic [7:0]        rec_count,
  output logic [7:0]        drop_count
);

  logic [PERSON_W-1:0] w_person;
  logic [WEEK_W-1:0]   w_week;
  logic [FIN_W-1:0]    w_fin;
  logic [ST_W-1:0]     w_state;

  assign w_person = status_word[PERSON_LSB +: PERSON_W];
  assign w_week   = status_word[WEEK_LSB +: WEEK_W];
  assign w_fin    = status_word[FIN_LSB +: FIN_W];
  assign w_state  = status_word[ST_LSB +: ST_W];

  trk_state_t          trk_state;
  logic [PERSON_W-1:0] cur_person;
  logic [WEEK_W-1:0]   start_week;
  logic [WEEK_W-1:0]   finish_week;
  logic [FIN_W-1:0]    finish_count;
  logic [ST_W-1:0]     max_state;
  logic                locked;
  logic                seen_f;

  logic             tracking;
  logic             legal;
  logic             person_change;
  logic             push;
  logic             pop;
  logic             drop;
  logic             do_capture;
  logic             do_update;
  logic             full;
  logic             empty;
  logic [REC_W-1:0] push_data;

  assign tracking      = (trk_state == TRK_TRACK);
  assign legal         = status_valid && (w_state != ST_ILLEGAL);
  assign person_change = tracking && legal && (w_person != cur_person);
  assign push          = tracking && (flush || person_change);
  // A flush closes the record; any legal word in the same cycle opens a fresh one.
  assign do_capture    = legal && (!tracking || flush || person_change);
  assign do_update     = legal && tracking && !flush && !person_change;
  assign push_data     = pack_record(cur_person, finish_week, finish_count, max_state, locked);
  assign rpt_valid     = !empty;
  assign pop           = rpt_valid && rpt_ready;
  assign drop          = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      trk_state     <= TRK_IDLE;
      cur_person    <= '0;
      start_week    <= '0;
      finish_week   <= '0;
      finish_count  <= '0;
      max_state     <= '0;
      locked        <= 1'b0;
      seen_f        <= 1'b0;
      overflow      <= 1'b0;
      illegal_state <= 1'b0;
    end else begin
      if (status_valid && w_state == ST_ILLEGAL) illegal_state <= 1'b1;
      if (drop) overflow <= 1'b1;
      if (do_capture) begin
        trk_state    <= TRK_TRACK;
        cur_person   <= w_person;
        start_week   <= w_week;
        max_state    <= w_state;
        finish_week  <= '0;
        finish_count <= '0;
        locked       <= 1'b0;
        seen_f       <= (w_state == F);
      end else begin
        if (flush) trk_state <= TRK_IDLE;
        if (do_update) begin
          if (w_state > max_state) max_state <= w_state;
          // Modulo-128 difference keeps the elapsed count right across a week wrap.
          if (w_state == F && !seen_f) begin
            finish_week <= w_week - start_week;
            seen_f      <= 1'b1;
          end
          finish_count <= w_fin;
          if (w_fin == FIN_LOCK && w_state == F) locked <= 1'b1;
        end
      end
    end
  end

  netflix_rpt_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head_data (rpt_data),
    .full      (full),
    .empty     (empty)
  );

`ifdef NETFLIX_DEC_STATS_EN
  logic       accept;
  logic [7:0] rec_cnt_q;
  logic [7:0] drop_cnt_q;

  assign accept = push && !drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (accept && rec_cnt_q != 8'hFF) rec_cnt_q <= rec_cnt_q + 8'd1;
      if (drop && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign rec_count  = rec_cnt_q;
  assign drop_count = drop_cnt_q;
`else
  assign rec_count  = '0;
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_netflix_trace_decoder.sv
// tb/tb_netflix_trace_decoder.sv - directed and randomized checks of netflix_trace_decoder against a queue model
module tb_netflix_trace_decoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] status_word = '0;
  logic        status_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] rpt_data;
  logic        rpt_valid;
  logic        rpt_ready = 1'b0;
  logic        overflow;
  logic        illegal_state;
  logic [7:0]  rec_count;
  logic [7:0]  drop_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  netflix_trace_decoder #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .status_word   (status_word),
    .status_valid  (status_valid),
    .flush         (flush),
    .rpt_data      (rpt_data),
    .rpt_valid     (rpt_valid),
    .rpt_ready     (rpt_ready),
    .overflow      (overflow),
    .illegal_state (illegal_state),
    .rec_count     (rec_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: one open record per person, reports held in a plain queue.
  bit          m_act;
  logic [2:0]  m_person, m_max;
  logic [6:0]  m_start, m_fw;
  logic [1:0]  m_fc;
  bit          m_lk, m_seenf;
  logic [15:0] q[$];
  bit          m_valid, m_ovf, m_ill;
  int          m_rec, m_drop;

  function automatic logic [14:0] mk_word(input int p, input int wk, input int fin, input int st);
    logic [2:0] pp; logic [6:0] ww; logic [1:0] ff; logic [2:0] ss;
    pp = p[2:0]; ww = wk[6:0]; ff = fin[1:0]; ss = st[2:0];
    return {pp, ww, ff, ss};
  endfunction

  task automatic capture(input logic [14:0] w);
    m_act = 1; m_person = w[14:12]; m_start = w[11:5]; m_max = w[2:0];
    m_fw = 0; m_fc = 0; m_lk = 0; m_seenf = (w[2:0] == 3'd6);
  endtask

  always @(posedge clk) begin
    int          sz0;
    bit          pop, push, legal;
    logic [15:0] rec;
    if (rst) begin
      q.delete(); m_act = 0; m_valid = 0; m_ovf = 0; m_ill = 0; m_rec = 0; m_drop = 0;
    end else begin
      sz0   = q.size();
      pop   = m_valid && rpt_ready;
      push  = 0;
      rec   = {m_person, m_fw, m_fc, m_max, m_lk};
      legal = status_valid && (status_word[2:0] != 3'd7);
      if (status_valid && status_word[2:0] == 3'd7) m_ill = 1;
      if (m_act && flush) begin push = 1; m_act = 0; end
      if (legal) begin
        if (!m_act) capture(status_word);
        else if (status_word[14:12] != m_person) begin push = 1; capture(status_word); end
        else begin
          if (status_word[2:0] > m_max) m_max = status_word[2:0];
          if (status_word[2:0] == 3'd6 && !m_seenf) begin
            m_fw = 7'((int'(status_word[11:5]) - int'(m_start) + 128) % 128);
            m_seenf = 1;
          end
          m_fc = status_word[4:3];
          if (status_word[4:3] == 2'd3 && status_word[2:0] == 3'd6) m_lk = 1;
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < DEPTH) begin q.push_back(rec); if (m_rec < 255) m_rec++; end
        else begin m_ovf = 1; if (m_drop < 255) m_drop++; end
      end
      m_valid = (sz0 > 0) && (q.size() > 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("rpt_valid", 32'(rpt_valid), 32'(m_valid));
      if (m_valid) chk("rpt_data", 32'(rpt_data), 32'(q[0]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("illegal_state", 32'(illegal_state), 32'(m_ill));
`ifdef NETFLIX_DEC_STATS_EN
      chk("rec_count", 32'(rec_count), 32'(m_rec));
      chk("drop_count", 32'(drop_count), 32'(m_drop));
`else
      chk("rec_count_tied", 32'(rec_count), 32'd0);
      chk("drop_count_tied", 32'(drop_count), 32'd0);
`endif
    end
  end

  task automatic drv(input logic v, input logic [14:0] w, input logic f);
    status_valid = v; status_word = w; flush = f;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(1'b0, 15'd0, 1'b0);
  endtask

  initial begin
    int rp, rw;
    @(negedge clk);
    @(negedge clk);
    chk("reset_rpt_valid", 32'(rpt_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    chk("reset_illegal", 32'(illegal_state), 32'd0);
    chk("reset_counts", 32'({rec_count, drop_count}), 32'd0);
    rst = 1'b0;
    chk_en = 1;

    // Single person, F first seen at week 17
    for (int k = 0; k < 8; k++)
      drv(1'b1, mk_word(1, 10 + k, (k == 7) ? 1 : 0, (k == 0) ? 0 : k - 1), 1'b0);
    drv(1'b1, mk_word(2, 20, 0, 0), 1'b0);
    chk("single_valid_lag", 32'(rpt_valid), 32'd0);
    idle(1);
    chk("single_valid", 32'(rpt_valid), 32'd1);
    chk("single_data", 32'(rpt_data), 32'h21DC);
    chk("model_single", 32'(q[0]), 32'h21DC);
    rpt_ready = 1'b1;
    idle(3);

    // Week wrap 125 -> 3
    drv(1'b0, 15'd0, 1'b1);
    idle(3);
    rpt_ready = 1'b0;
    drv(1'b1, mk_word(3, 125, 0, 1), 1'b0);
    drv(1'b1, mk_word(3, 127, 0, 3), 1'b0);
    drv(1'b1, mk_word(3, 1, 0, 5), 1'b0);
    drv(1'b1, mk_word(3, 3, 2, 6), 1'b0);
    drv(1'b0, 15'd0, 1'b1);
    idle(1);
    chk("wrap_finish_week", 32'(rpt_data[12:6]), 32'd6);
    rpt_ready = 1'b1;
    idle(3);

    // Locked viewer, then a flush while idle
    rpt_ready = 1'b0;
    drv(1'b1, mk_word(4, 4, 0, 5), 1'b0);
    drv(1'b1, mk_word(4, 5, 3, 6), 1'b0);
    drv(1'b0, 15'd0, 1'b1);
    drv(1'b0, 15'd0, 1'b1);
    idle(1);
    chk("locked_bit", 32'(rpt_data[0]), 32'd1);
    chk("locked_fin_count", 32'(rpt_data[5:4]), 32'd3);
    rpt_ready = 1'b1;
    idle(1);
    chk("idle_flush_no_push", 32'(rpt_valid), 32'd0);
    idle(1);
    chk("idle_flush_no_push2", 32'(rpt_valid), 32'd0);

    // Backpressure: 5 person changes into a 4-deep FIFO
    rpt_ready = 1'b0;
    for (int p = 1; p <= 6; p++) drv(1'b1, mk_word(p, 1, 0, 1), 1'b0);
    idle(2);
    chk("bp_overflow", 32'(overflow), 32'd1);
`ifdef NETFLIX_DEC_STATS_EN
    chk("bp_drop_count", 32'(drop_count), 32'd1);
`endif
    rpt_ready = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      chk("bp_drain_valid", 32'(rpt_valid), 32'd1);
      chk("bp_drain_person", 32'(rpt_data[15:13]), 32'(p));
      idle(1);
    end
    chk("bp_drained", 32'(rpt_valid), 32'd0);

    // Flush together with a person change
    rpt_ready = 1'b0;
    drv(1'b1, mk_word(7, 10, 0, 3), 1'b1);
    drv(1'b1, mk_word(7, 11, 0, 1), 1'b0);
    drv(1'b0, 15'd0, 1'b1);
    idle(1);
    chk("simul_old_rec", 32'(rpt_data), 32'hC002);
    rpt_ready = 1'b1;
    idle(1);
    chk("simul_new_rec", 32'(rpt_data), 32'hE006);
    idle(1);
    chk("simul_two_only", 32'(rpt_valid), 32'd0);

    // Illegal state is ignored by the tracker
    rpt_ready = 1'b0;
    drv(1'b1, mk_word(1, 20, 0, 2), 1'b0);
    drv(1'b1, mk_word(5, 21, 3, 7), 1'b0);
    chk("illegal_set", 32'(illegal_state), 32'd1);
    drv(1'b1, mk_word(1, 22, 0, 1), 1'b0);
    drv(1'b0, 15'd0, 1'b1);
    idle(1);
    chk("illegal_rec", 32'(rpt_data), 32'h2004);
    chk("pre_rst_overflow", 32'(overflow), 32'd1);

    // Mid-stream reset
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst_valid", 32'(rpt_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_illegal", 32'(illegal_state), 32'd0);

    // Randomized traffic
    rp = 0; rw = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) rpt_ready = ~rpt_ready;
      else if ($urandom_range(0, 3) == 0) rpt_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 6) == 0) rp = $urandom_range(0, 7);
      if ($urandom_range(0, 20) == 0) rw = $urandom_range(0, 127); else rw = (rw + 1) % 128;
      drv($urandom_range(0, 9) < 7,
          mk_word(rp, rw, $urandom_range(0, 3),
                  ($urandom_range(0, 15) == 0) ? 7 : $urandom_range(0, 6)),
          $urandom_range(0, 24) == 0);
    end
    rst = 1'b0;
    rpt_ready = 1'b1;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
